// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule generator.
// Loads one 512-bit block as 16 big-endian words, then emits W[0..NUM_ROUNDS-1]
// in order, each tagged with its round index. Only a 16-word sliding window is
// stored: each emitted word leaves the window, and the expanded word enters at the top.
module sha256_msg_sched #(
    parameter int NUM_ROUNDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_w,
    output logic [7:0]  out_t,
    output logic        out_last,
    output logic        busy
);

    localparam logic [7:0] LAST_T = 8'(NUM_ROUNDS - 1);

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [7:0]  t_reg, t_next;
    logic        load_en;
    logic        shift_en;
    logic [31:0] window_reg  [16];
    logic [31:0] window_next [16];
    logic [31:0] w_new;

    // Small sigma functions of the SHA-256 message expansion.
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Window slot 0 holds W[t]; the new word W[t+16] is built from W[t+14],
    // W[t+9], W[t+1] and W[t], all of which sit at fixed window positions.
    assign w_new = ssig1(window_reg[14]) + window_reg[9]
                 + ssig0(window_reg[1]) + window_reg[0];

    // Control state, load count and round index; reset discards any partial block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= LOAD;
            cnt_reg   <= 4'd0;
            t_reg     <= 8'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            t_reg     <= t_next;
        end
    end

    // Next-state logic: LOAD counts in 16 words, EMIT steps t on every output transfer.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        t_next     = t_reg;
        load_en    = 1'b0;
        shift_en   = 1'b0;
        case (state_reg)
            LOAD: begin
                if (in_valid) begin
                    load_en  = 1'b1;
                    cnt_next = cnt_reg + 4'd1;
                    if (cnt_reg == 4'd15) begin
                        state_next = EMIT;
                        cnt_next   = 4'd0;
                        t_next     = 8'd0;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (t_reg == LAST_T) begin
                        // Last word leaves; the window content is no longer needed.
                        state_next = LOAD;
                        cnt_next   = 4'd0;
                        t_next     = 8'd0;
                    end else begin
                        shift_en = 1'b1;
                        t_next   = t_reg + 8'd1;
                    end
                end
            end
            default: begin
                state_next = LOAD;
                cnt_next   = 4'd0;
                t_next     = 8'd0;
            end
        endcase
    end

    // Per-slot next value: direct write while loading, shift down while emitting.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_win
            logic [31:0] shift_in;
            if (gi == 15) begin : g_top
                assign shift_in = w_new;
            end else begin : g_mid
                assign shift_in = window_reg[gi+1];
            end
            assign window_next[gi] = (load_en && (cnt_reg == 4'(gi))) ? in_word
                                   : shift_en                          ? shift_in
                                   :                                     window_reg[gi];
        end
    endgenerate

    // Window storage; contents are don't-care after reset so it carries no reset.
    always_ff @(posedge clk) begin
        window_reg <= window_next;
    end

    // Outputs decode directly from registered state; in_ready is forced low while reset is high.
    assign in_ready  = (state_reg == LOAD) && !reset;
    assign out_valid = (state_reg == EMIT);
    assign out_w     = (state_reg == EMIT) ? window_reg[0] : 32'd0;
    assign out_t     = t_reg;
    assign out_last  = (state_reg == EMIT) && (t_reg == LAST_T);
    assign busy      = (state_reg != LOAD) || (cnt_reg != 4'd0);

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched: a reference schedule model fills a
// scoreboard when a block is queued for driving; observed output transfers are
// compared against it by each scenario task.
module tb_sha256_msg_sched;

    typedef struct packed {
        logic [7:0]  t;
        logic [31:0] w;
        logic        last;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_word = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_w;
    logic [7:0]  out_t;
    logic        out_last;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    rec_t        exp_q[$];
    rec_t        obs_q[$];
    logic [31:0] in_q[$];
    logic [31:0] blk[16];
    logic [31:0] abc_blk[16];

    // Protocol statistics gathered while driving
    int   lat_bad, stable_bad, ir_emit_bad, ir_after_last_bad, outw_zero_bad;
    int   block_in_cnt;
    bit   expect_ov, prev_stall, prev_last_xfer, timed_out;
    logic [31:0] prev_w;
    logic [7:0]  prev_t;

    sha256_msg_sched #(.NUM_ROUNDS(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_w     (out_w),
        .out_t     (out_t),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] m_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] m_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Queue blk for driving and push its 64 expected schedule words
    task automatic queue_block();
        logic [31:0] w[64];
        rec_t r;
        for (int i = 0; i < 64; i++) begin
            if (i < 16) w[i] = blk[i];
            else w[i] = m_s1(w[i-2]) + w[i-7] + m_s0(w[i-15]) + w[i-16];
            r.t = 8'(i);
            r.w = w[i];
            r.last = (i == 63);
            exp_q.push_back(r);
        end
        for (int i = 0; i < 16; i++) in_q.push_back(blk[i]);
    endtask

    task automatic random_block();
        for (int i = 0; i < 16; i++) blk[i] = $urandom();
    endtask

    task automatic clear_stats();
        lat_bad = 0; stable_bad = 0; ir_emit_bad = 0; ir_after_last_bad = 0;
        outw_zero_bad = 0; block_in_cnt = 0; expect_ov = 0; prev_stall = 0;
        prev_last_xfer = 0; timed_out = 0; obs_q.delete();
    endtask

    // Drives queued input words and collects output transfers (no checking here).
    // Stops after n_out output transfers, or once in_q drains when n_out == 0.
    task automatic run_block(input int gap_max, input int rdy_pct, input int n_out,
                             input int max_cycles);
        int   cyc = 0;
        int   gap = 0;
        logic ov, ol, ir;
        logic [31:0] ow;
        logic [7:0]  ot;
        rec_t r;
        while ((n_out > 0) ? (obs_q.size() < n_out) : (in_q.size() != 0)) begin
            @(negedge clk);
            cyc++;
            if (cyc > max_cycles) begin
                timed_out = 1;
                break;
            end
            ov = out_valid; ow = out_w; ot = out_t; ol = out_last; ir = in_ready;
            if (expect_ov && !ov) lat_bad++;
            expect_ov = 0;
            if (prev_stall && (!ov || ow !== prev_w || ot !== prev_t)) stable_bad++;
            if (ov && ir) ir_emit_bad++;
            if (prev_last_xfer && !ir) ir_after_last_bad++;
            if (!ov && ow !== 32'd0) outw_zero_bad++;
            if (in_q.size() != 0 && gap == 0) begin
                in_valid = 1'b1;
                in_word  = in_q[0];
            end else begin
                in_valid = 1'b0;
                in_word  = 32'd0;
                if (gap > 0) gap--;
            end
            out_ready = (int'($urandom_range(0, 99)) < rdy_pct);
            if (in_valid && ir) begin
                void'(in_q.pop_front());
                gap = $urandom_range(0, gap_max);
                block_in_cnt++;
                if (block_in_cnt == 16) begin
                    block_in_cnt = 0;
                    expect_ov = 1;
                end
            end
            prev_last_xfer = 0;
            if (ov && out_ready) begin
                r.t = ot; r.w = ow; r.last = ol;
                obs_q.push_back(r);
                prev_last_xfer = ol;
            end
            prev_stall = ov && !out_ready;
            prev_w = ow;
            prev_t = ot;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_word = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_t !== 8'd0 ||
            out_last !== 1'b0 || busy !== 1'b0 || out_w !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: got ir=%b ov=%b t=%0d last=%b busy=%b w=%h want 1 0 0 0 0 0",
                     in_ready, out_valid, out_t, out_last, busy, out_w);
        end
        $display("test_reset: done");
    endtask

    task automatic test_abc();
        rec_t e;
        clear_stats();
        blk = abc_blk;
        queue_block();
        run_block(0, 100, 64, 400);
        n_checks++;
        if (timed_out || obs_q.size() != 64) begin
            n_fail++; $display("FAIL abc_count: got %0d want 64", obs_q.size());
        end
        n_checks++;
        if (lat_bad !== 0) begin
            n_fail++; $display("FAIL abc_latency: got %0d late starts want 0", lat_bad);
        end
        if (obs_q.size() == 64) begin
            n_checks++;
            if (obs_q[0].w !== 32'h61626380 || obs_q[15].w !== 32'h00000018 ||
                obs_q[16].w !== 32'h61626380 || obs_q[17].w !== 32'h000F0000 ||
                obs_q[63].w !== 32'h12B1EDEB) begin
                n_fail++;
                $display("FAIL abc_golden: got %h %h %h %h %h want 61626380 00000018 61626380 000f0000 12b1edeb",
                         obs_q[0].w, obs_q[15].w, obs_q[16].w, obs_q[17].w, obs_q[63].w);
            end
        end
        foreach (obs_q[i]) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q[i] !== e) begin
                n_fail++;
                $display("FAIL abc_word: got t=%0d w=%h last=%b want t=%0d w=%h last=%b",
                         obs_q[i].t, obs_q[i].w, obs_q[i].last, e.t, e.w, e.last);
            end
        end
        n_checks++;
        if (outw_zero_bad !== 0 || ir_emit_bad !== 0) begin
            n_fail++; $display("FAIL abc_idle_outputs: got %0d/%0d violations want 0", outw_zero_bad, ir_emit_bad);
        end
        exp_q.delete();
        $display("test_abc: %0d words", obs_q.size());
    endtask

    task automatic test_backpressure();
        rec_t e;
        clear_stats();
        blk = abc_blk;
        queue_block();
        run_block(0, 50, 64, 2000);
        n_checks++;
        if (timed_out || obs_q.size() != 64) begin
            n_fail++; $display("FAIL bp_count: got %0d want 64", obs_q.size());
        end
        n_checks++;
        if (stable_bad !== 0) begin
            n_fail++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stable_bad);
        end
        foreach (obs_q[i]) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q[i] !== e) begin
                n_fail++;
                $display("FAIL bp_word: got t=%0d w=%h want t=%0d w=%h", obs_q[i].t, obs_q[i].w, e.t, e.w);
            end
        end
        exp_q.delete();
        $display("test_backpressure: %0d words", obs_q.size());
    endtask

    task automatic test_input_stalls();
        rec_t e;
        clear_stats();
        random_block();
        queue_block();
        run_block(5, 100, 64, 1000);
        n_checks++;
        if (timed_out || obs_q.size() != 64) begin
            n_fail++; $display("FAIL stall_count: got %0d want 64", obs_q.size());
        end
        n_checks++;
        if (ir_emit_bad !== 0) begin
            n_fail++; $display("FAIL stall_in_ready_emit: got %0d cycles want 0", ir_emit_bad);
        end
        for (int i = 0; i < 16 && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].w !== blk[i]) begin
                n_fail++; $display("FAIL stall_passthru: t=%0d got %h want %h", i, obs_q[i].w, blk[i]);
            end
        end
        foreach (obs_q[i]) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q[i] !== e) begin
                n_fail++;
                $display("FAIL stall_word: got t=%0d w=%h want t=%0d w=%h", obs_q[i].t, obs_q[i].w, e.t, e.w);
            end
        end
        exp_q.delete();
        $display("test_input_stalls: %0d words", obs_q.size());
    endtask

    task automatic test_back_to_back();
        rec_t e;
        clear_stats();
        random_block();
        queue_block();
        random_block();
        queue_block();
        run_block(0, 100, 128, 600);
        n_checks++;
        if (timed_out || obs_q.size() != 128) begin
            n_fail++; $display("FAIL b2b_count: got %0d want 128", obs_q.size());
        end
        n_checks++;
        if (ir_after_last_bad !== 0 || lat_bad !== 0) begin
            n_fail++; $display("FAIL b2b_turnaround: got %0d/%0d violations want 0", ir_after_last_bad, lat_bad);
        end
        foreach (obs_q[i]) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q[i] !== e) begin
                n_fail++;
                $display("FAIL b2b_word: idx=%0d got t=%0d w=%h want t=%0d w=%h", i, obs_q[i].t, obs_q[i].w, e.t, e.w);
            end
        end
        exp_q.delete();
        $display("test_back_to_back: %0d words", obs_q.size());
    endtask

    task automatic test_reset_mid_emit();
        rec_t e;
        clear_stats();
        blk = abc_blk;
        queue_block();
        run_block(0, 100, 21, 400);
        foreach (obs_q[i]) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q[i] !== e) begin
                n_fail++; $display("FAIL rst_emit_pre: got t=%0d w=%h want t=%0d w=%h", obs_q[i].t, obs_q[i].w, e.t, e.w);
            end
        end
        exp_q.delete();
        pulse_reset();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_emit_state: got ov=%b ir=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
        end
        clear_stats();
        in_q.delete();
        blk = abc_blk;
        queue_block();
        run_block(0, 100, 64, 400);
        n_checks++;
        if (timed_out || obs_q.size() != 64 || obs_q[0].t !== 8'd0 || obs_q[17].w !== 32'h000F0000) begin
            n_fail++; $display("FAIL rst_emit_restart: got n=%0d (t0/w17 wrong or short) want 64 from t=0 with W17=000f0000", obs_q.size());
        end
        foreach (obs_q[i]) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q[i] !== e) begin
                n_fail++; $display("FAIL rst_emit_word: got t=%0d w=%h want t=%0d w=%h", obs_q[i].t, obs_q[i].w, e.t, e.w);
            end
        end
        exp_q.delete();
        $display("test_reset_mid_emit: done");
    endtask

    task automatic test_reset_mid_load();
        rec_t e;
        clear_stats();
        for (int i = 0; i < 7; i++) in_q.push_back($urandom());
        run_block(0, 100, 0, 100);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL rst_load_busy: got %b want 1", busy);
        end
        reset = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_load_state: got busy=%b ir=%b want 0 1", busy, in_ready);
        end
        clear_stats();
        in_q.delete();
        random_block();
        queue_block();
        run_block(2, 100, 64, 600);
        for (int i = 0; i < 16 && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].w !== blk[i]) begin
                n_fail++; $display("FAIL rst_load_passthru: t=%0d got %h want %h", i, obs_q[i].w, blk[i]);
            end
        end
        n_checks++;
        if (timed_out || obs_q.size() != 64) begin
            n_fail++; $display("FAIL rst_load_count: got %0d want 64", obs_q.size());
        end
        foreach (obs_q[i]) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q[i] !== e) begin
                n_fail++; $display("FAIL rst_load_word: got t=%0d w=%h want t=%0d w=%h", obs_q[i].t, obs_q[i].w, e.t, e.w);
            end
        end
        exp_q.delete();
        $display("test_reset_mid_load: done");
    endtask

    initial begin
        abc_blk[0] = 32'h61626380;
        for (int i = 1; i < 15; i++) abc_blk[i] = 32'h00000000;
        abc_blk[15] = 32'h00000018;
        clear_stats();
        test_reset();
        test_abc();
        test_backpressure();
        test_input_stalls();
        test_back_to_back();
        test_reset_mid_emit();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
- Producer-side SHA-256 message schedule generator; supplies the per-round word W[t] and round index t consumed by the round operator.
- Accepts one 512-bit message block as 16 big-endian 32-bit words over a valid/ready input stream.
- Emits W[0..63] in order over a valid/ready output stream, each word tagged with its round index t.
- Uses a 16-word sliding window, so storage is 16 x 32 bits regardless of round count.

Parameters:
- NUM_ROUNDS, 64, number of schedule words emitted per block; fixed at 64 for SHA-256, parameterised only for verification shortening (legal range 16..64).

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  in_word holds a valid message word
- in_ready  out  1  block accepts a message word this cycle
- in_word  in  32  message word M[i], word 0 first
- out_valid  out  1  out_w/out_t are valid
- out_ready  in  1  consumer accepts out_w this cycle
- out_w  out  32  schedule word W[t]
- out_t  out  8  round index t, 0..NUM_ROUNDS-1
- out_last  out  1  high with out_valid when out_t == NUM_ROUNDS-1
- busy  out  1  high in any state other than LOAD, or in LOAD with load count != 0

Behaviour:
- Reset (synchronous, active-high, dominant over all other inputs):
  - state <= LOAD, load count <= 0, t <= 0, window contents don't-care.
  - Registered outputs reset to: out_valid=0, out_t=0, out_last=0, busy=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - in_ready is 0 during any cycle in which reset is high.
  - out_w is 0 while out_valid=0. This is a bench requirement.
- Handshake:
  - A transfer occurs on a rising edge where valid && ready.
  - out_valid, once asserted, holds with out_w/out_t stable until the transfer.
  - in_word is ignored when in_ready=0.
- State LOAD:
  - in_ready=1, out_valid=0.
  - Each input transfer writes in_word into window[cnt] and increments cnt.
  - The transfer at cnt==15 moves to EMIT and sets t=0.
  - in_valid gaps stall loading indefinitely without loss.
- State EMIT:
  - in_ready=0, out_valid=1.
  - out_w=window[0], out_t=t, out_last=(t==NUM_ROUNDS-1).
  - Latency: out_valid rises the cycle after the 16th input transfer.
  - On an output transfer with t < NUM_ROUNDS-1:
    - window[i] <= window[i+1] for i=0..14.
    - window[15] <= s1(window[14]) + window[9] + s0(window[1]) + window[0].
    - t <= t+1.
  - The first 16 emitted words are therefore M[0..15] unchanged.
  - Without an output transfer, the window and t hold (backpressure).
  - Output transfer at t==NUM_ROUNDS-1: go to LOAD, cnt=0, out_valid=0 next cycle, in_ready=1 next cycle. Blocks do not overlap.
- Arithmetic:
  - s0(x) = ror(x,7) ^ ror(x,18) ^ (x >> 3).
  - s1(x) = ror(x,17) ^ ror(x,19) ^ (x >> 10).
  - Additions are modulo 2^32 with carries discarded.
  - ror is a 32-bit rotate right.
- Throughput: one word per cycle with out_ready held high, giving 16 load cycles + 64 emit cycles per block.
- Reset mid-block, in LOAD or EMIT: the partial block is discarded with no further output. The next block starts at word 0.
- in_valid high in EMIT: ignored, and the word is not consumed. The upstream producer must hold it.

Test Plan:
- "abc" block: feed 0x61626380, fourteen words of 0x00000000, then 0x00000018, with out_ready=1.
  - Required: out_valid rises 1 cycle after the 16th input.
  - t=0 -> 0x61626380, t=15 -> 0x00000018, t=16 -> 0x61626380, t=17 -> 0x000F0000, t=63 -> 0x12B1EDEB.
  - All 64 words match the golden software model.
  - out_last high only at t=63.
- Output backpressure: same block, out_ready toggled randomly (~50%).
  - Required: identical sequence W[0..63] to the first test.
  - out_w/out_t stable whenever out_valid && !out_ready.
  - No t skipped or repeated.
- Input stalls: 16 random words with random in_valid gaps of 0..5 cycles.
  - Required: t=0..15 reproduce the input words exactly.
  - t=16..63 match the model.
  - in_ready=0 throughout EMIT.
- Back-to-back blocks: two random blocks, in_valid held high, out_ready=1.
  - Required: in_ready=1 the cycle after the t=63 transfer of block 1.
  - Block 2 outputs match the model with no cross-block contamination.
- Reset mid-operation: assert reset for 1 cycle after the t=20 transfer.
  - Required: next cycle out_valid=0, in_ready=1, busy=0.
  - A fresh "abc" block then yields t=17 -> 0x000F0000.
- Reset during LOAD after 7 words.
  - Required: the 7 words are discarded.
  - The following 16 words are treated as M[0..15], checked at t=0..15.
